fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Owns the single write port shared by the red/green/blue frame buffers. It arbitrates between two pixel requesters, the cursor painter (port 0) and the brush/stroke engine (port 1), using round-robin. It also contains a full-screen clear sweeper that takes the port exclusively when triggered. It sits between the painting engines and the three buffer instances, and its registered outputs drive their write address, data and write enable directly.

## Interface
- W_RES, 640: horizontal resolution in pixels; valid x is 0..W_RES-1.
- H_RES, 480: vertical resolution in pixels; valid y is 0..H_RES-1.

- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-low reset
- paint_en  in  1  when low, no requester is granted (requesters stall); does not affect clearing
- clear_start  in  1  single-cycle pulse; starts a full-screen clear
- clear_rgb  in  24  clear colour {R,G,B}, latched on the accepted clear_start
- req0, req1  in  1  request from port 0 / port 1
- x0, x1  in  11  requested pixel x
- y0, y1  in  11  requested pixel y
- rgb0, rgb1  in  24  requested colour {R,G,B}
- gnt0, gnt1  out  1  combinational grant; transfer occurs at a rising edge where req&gnt=1
- wr_en  out  1  buffer write enable (registered)
- wr_x, wr_y  out  11  buffer write coordinates (registered)
- wr_r, wr_g, wr_b  out  8  buffer write data (registered)
- clearing  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse, coincident with the last clear write
- drop  out  1  one-cycle pulse marking a consumed out-of-range request

## Operation
- The FSM has two states: ARB (reset state) and CLEAR.
- ARB → CLEAR when clear_start=1. At that edge:
  - clear_rgb is latched;
  - cx and cy are zeroed;
  - the clear request beats any same-cycle req (gnt0=gnt1=0 whenever clear_start=1).
- In ARB:
  - gnt = paint_en & !clear_start & requester selection.
  - With a single requester, that requester is granted.
  - With both requesting, the port other than last_served is granted.
  - last_served updates on every transfer.
  - Reset value of last_served is 1, so port 0 wins the first tie.
- Request rules:
  - A requester holds req, x, y and rgb stable until the transfer edge.
  - It may deassert req only after the transfer.
  - Back-to-back transfers from the same port are allowed when the other port is idle.
- Transfer:
  - If x<W_RES and y<H_RES, the next cycle has wr_en=1 with the transferred coordinates and colour.
  - Otherwise the request is consumed: wr_en=0 and drop=1 for one cycle.
- In CLEAR:
  - gnt0=gnt1=0.
  - One write per cycle, raster order: x increments 0..W_RES-1, wraps to 0 and increments y.
  - Counters cx and cy are 11 bits each.
  - clear_start during CLEAR is ignored.
  - paint_en is ignored in CLEAR.
- At pixel (W_RES-1, H_RES-1): the last write is issued with clear_done=1, and the FSM returns to ARB at the same edge.
- Reset (asserted at any time, including mid-clear):
  - State = ARB; counters = 0; last_served = 1.
  - wr_en=0, wr_x=wr_y=0, wr_r=wr_g=wr_b=0, clearing=0, clear_done=0, drop=0.
  - A partial clear is abandoned and not resumed.

## Timing
- Grant: combinational from req, paint_en, clear_start, state and last_served.
- Paint latency: transfer at edge k → wr_* valid in the cycle after edge k (1 cycle), for exactly 1 cycle.
- Sustained paint throughput: 1 pixel/cycle; with both ports requesting, they alternate 0,1,0,1.
- Clear sequence, with clear_start sampled at edge k:
  - clearing=1 after edge k;
  - first write (0,0) is valid after edge k+1;
  - last write (W_RES-1, H_RES-1) is valid after edge k+W_RES*H_RES (307200 at defaults), together with clear_done.
- After the clear:
  - clearing=0 from edge k+W_RES*H_RES;
  - a grant may assert in that same cycle;
  - the first paint write follows one cycle later.
- No write cycle is lost or duplicated at the CLEAR→ARB switch.

## Test plan
- Reset release with no requests: all outputs 0, gnt0=gnt1=0, across 10 cycles.
- Single requester: req0 with (100,200,0xFF8000) and paint_en=1 → gnt0=1; the next cycle shows wr_en=1, wr_x=100, wr_y=200, wr_r=FF, wr_g=80, wr_b=00.
- Contention: req0 and req1 held high for 6 cycles → grant order 0,1,0,1,0,1; wr_* alternates between the two payloads.
- Clear with W_RES=8, H_RES=4 and clear_rgb=0x102030:
  - 32 consecutive writes with wr_en=1;
  - order (0,0),(1,0)…(7,3);
  - clear_done only on (7,3);
  - gnt low throughout despite req0 held.
- Clear precedence and abort:
  - clear_start and req1 in the same cycle → gnt1=0, clear starts.
  - Reset asserted at write 10 → outputs zero immediately (asynchronous).
  - After release, req0 is served with no clear resumption.
- Out-of-range and stall:
  - req1 at (640,0) → consumed, wr_en stays 0, drop=1 for one cycle.
  - With paint_en=0, req0 stays ungranted until paint_en=1.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester/grant and frame buffer write bundle for fb_write_arbiter
interface fb_write_arbiter_if;
  // painting side
  logic        paint_en;
  logic        clear_start;
  logic [23:0] clear_rgb;
  logic        req0;
  logic        req1;
  logic [10:0] x0;
  logic [10:0] x1;
  logic [10:0] y0;
  logic [10:0] y1;
  logic [23:0] rgb0;
  logic [23:0] rgb1;
  logic        gnt0;
  logic        gnt1;
  // frame buffer side
  logic        wr_en;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [7:0]  wr_r;
  logic [7:0]  wr_g;
  logic [7:0]  wr_b;
  logic        clearing;
  logic        clear_done;
  logic        drop;

  modport master (
    output paint_en, clear_start, clear_rgb,
    output req0, req1, x0, x1, y0, y1, rgb0, rgb1,
    input  gnt0, gnt1,
    input  wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    input  clearing, clear_done, drop
  );

  modport slave (
    input  paint_en, clear_start, clear_rgb,
    input  req0, req1, x0, x1, y0, y1, rgb0, rgb1,
    output gnt0, gnt1,
    output wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    output clearing, clear_done, drop
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin write port arbiter with full-screen clear sweeper
module fb_write_arbiter #(
  parameter int W_RES = 640,
  parameter int H_RES = 480
) (
  input  logic                clock,
  input  logic                reset,
  fb_write_arbiter_if.slave   bus
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [10:0] X_LAST = 11'(W_RES - 1);
  localparam logic [10:0] Y_LAST = 11'(H_RES - 1);
  localparam logic [11:0] X_LIM  = 12'(W_RES);
  localparam logic [11:0] Y_LIM  = 12'(H_RES);

  state_t      state;
  logic        last_served;
  logic [10:0] cx;
  logic [10:0] cy;
  logic [23:0] clr_rgb;

  logic        grant_ok;
  logic        pick1;
  logic        xfer;
  logic [10:0] sel_x;
  logic [10:0] sel_y;
  logic [23:0] sel_rgb;
  logic        in_range;

  logic        wr_en_q;
  logic [10:0] wr_x_q;
  logic [10:0] wr_y_q;
  logic [23:0] wr_rgb_q;
  logic        clearing_q;
  logic        clear_done_q;
  logic        drop_q;

  // Grant selection: a lone requester wins, a tie goes to the port not served last.
  // A clear request in the same cycle suppresses both grants.
  always_comb begin
    grant_ok = (state == ARB) && bus.paint_en && !bus.clear_start;
    if (bus.req0 && bus.req1) begin
      pick1 = !last_served;
    end else begin
      pick1 = bus.req1;
    end
    bus.gnt0 = grant_ok && bus.req0 && !pick1;
    bus.gnt1 = grant_ok && bus.req1 && pick1;
    xfer     = bus.gnt0 || bus.gnt1;
    sel_x    = pick1 ? bus.x1   : bus.x0;
    sel_y    = pick1 ? bus.y1   : bus.y0;
    sel_rgb  = pick1 ? bus.rgb1 : bus.rgb0;
    in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  end

  // Arbiter/sweeper FSM; every buffer-facing output is registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ARB;
      last_served  <= 1'b1;
      cx           <= '0;
      cy           <= '0;
      clr_rgb      <= '0;
      wr_en_q      <= 1'b0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_rgb_q     <= '0;
      clearing_q   <= 1'b0;
      clear_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      clear_done_q <= 1'b0;
      drop_q       <= 1'b0;
      case (state)
        ARB: begin
          if (bus.clear_start) begin
            state      <= CLEAR;
            clearing_q <= 1'b1;
            clr_rgb    <= bus.clear_rgb;
            cx         <= '0;
            cy         <= '0;
          end else if (xfer) begin
            last_served <= pick1;
            if (in_range) begin
              wr_en_q  <= 1'b1;
              wr_x_q   <= sel_x;
              wr_y_q   <= sel_y;
              wr_rgb_q <= sel_rgb;
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // One raster-order write per cycle; the final pixel also hands the port back.
          wr_en_q  <= 1'b1;
          wr_x_q   <= cx;
          wr_y_q   <= cy;
          wr_rgb_q <= clr_rgb;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy           <= '0;
              clear_done_q <= 1'b1;
              clearing_q   <= 1'b0;
              state        <= ARB;
            end else begin
              cy <= cy + 11'd1;
            end
          end else begin
            cx <= cx + 11'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_x       = wr_x_q;
  assign bus.wr_y       = wr_y_q;
  assign bus.wr_r       = wr_rgb_q[23:16];
  assign bus.wr_g       = wr_rgb_q[15:8];
  assign bus.wr_b       = wr_rgb_q[7:0];
  assign bus.clearing   = clearing_q;
  assign bus.clear_done = clear_done_q;
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - scoreboard bench for fb_write_arbiter with directed and random stimulus
module tb_fb_write_arbiter;

  localparam int W = 8;
  localparam int H = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fb_write_arbiter_if bus();

  fb_write_arbiter #(.W_RES(W), .H_RES(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    bit          drop;
    bit          done;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // reference model state
  bit   last  = 1'b1;   // port served most recently
  int   busy  = 0;      // clear cycles still owed
  bit   xfer0 = 1'b0;
  bit   xfer1 = 1'b0;
  bit [5:0] ord;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [10:0] rand_coord(input int lim);
    if ($urandom_range(0, 7) == 0) return 11'(lim + $urandom_range(0, 3));
    return 11'($urandom_range(0, lim - 1));
  endfunction

  // Monitor: every output cycle is either the scoreboard head that is due now, or idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("wr_flags", 64'({bus.wr_en, bus.drop, bus.clear_done}),
              64'({!e.drop, e.drop, e.done}));
        if (!e.drop)
          check("wr_data", 64'({bus.wr_x, bus.wr_y, bus.wr_r, bus.wr_g, bus.wr_b}),
                64'({e.x, e.y, e.rgb}));
      end else begin
        check("idle_flags", 64'({bus.wr_en, bus.drop, bus.clear_done}), 64'(0));
      end
    end
  end

  // One cycle of the reference model: inputs were set at the preceding negedge.
  task automatic tick();
    bit g0, g1;
    exp_t e;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (busy == 0 && bus.paint_en && !bus.clear_start) begin
      if (bus.req0 && bus.req1) begin
        if (last) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
    end
    check("gnt", 64'({bus.gnt0, bus.gnt1}), 64'({g0, g1}));
    check("clearing", 64'(bus.clearing), 64'(busy > 0));
    xfer0 = g0;
    xfer1 = g1;
    if (g0 || g1) begin
      last   = g1;
      e.due  = cyc + 1;
      e.x    = g1 ? bus.x1 : bus.x0;
      e.y    = g1 ? bus.y1 : bus.y0;
      e.rgb  = g1 ? bus.rgb1 : bus.rgb0;
      e.drop = !(e.x < W && e.y < H);
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    if (busy > 0) begin
      busy--;
    end else if (bus.clear_start) begin
      busy = W * H;
      for (int i = 0; i < W * H; i++) begin
        e.due  = cyc + 2 + i;
        e.drop = 1'b0;
        e.done = (i == W * H - 1);
        e.x    = 11'(i % W);
        e.y    = 11'(i / W);
        e.rgb  = bus.clear_rgb;
        exp_q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.paint_en    = 1'b1;
    bus.clear_start = 1'b0;
    bus.clear_rgb   = '0;
    bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.rgb0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.rgb1 = '0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_r, bus.wr_g, bus.wr_b,
                     bus.clearing, bus.clear_done, bus.drop, bus.gnt0, bus.gnt1}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    repeat (3) @(negedge clock);
    check_all_zero("reset_outputs");
    reset = 1'b1;

    // quiet cycles after reset
    repeat (10) tick();
    check_all_zero("post_reset_idle");

    // single requester
    bus.req0 = 1'b1; bus.x0 = 11'd5; bus.y0 = 11'd2; bus.rgb0 = 24'hFF8000;
    tick();
    bus.req0 = 1'b0;
    repeat (2) tick();

    // out-of-range requests on each axis are consumed with drop
    bus.req0 = 1'b1; bus.x0 = 11'd0; bus.y0 = 11'(H); bus.rgb0 = 24'h123456;
    tick();
    bus.req0 = 1'b0;
    tick();
    bus.req1 = 1'b1; bus.x1 = 11'(W); bus.y1 = 11'd0; bus.rgb1 = 24'hABCDEF;
    tick();
    bus.req1 = 1'b0;
    repeat (2) tick();

    // contention: strict alternation starting with port 0
    bus.req0 = 1'b1; bus.x0 = 11'd1; bus.y0 = 11'd1; bus.rgb0 = 24'h0000AA;
    bus.req1 = 1'b1; bus.x1 = 11'd6; bus.y1 = 11'd3; bus.rgb1 = 24'h55AA00;
    for (int i = 0; i < 6; i++) begin
      #1 ord[i] = bus.gnt1;
      tick();
    end
    check("contention_order", 64'(ord), 64'(6'b101010));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // stall while paint_en is low
    bus.paint_en = 1'b0;
    bus.req0 = 1'b1; bus.x0 = 11'd7; bus.y0 = 11'd0; bus.rgb0 = 24'h010203;
    repeat (3) tick();
    bus.paint_en = 1'b1;
    tick();
    bus.req0 = 1'b0;
    tick();

    // full clear with both requesters waiting; clear beats same-cycle req1
    bus.req1 = 1'b1; bus.x1 = 11'd2; bus.y1 = 11'd2; bus.rgb1 = 24'hC0FFEE;
    bus.req0 = 1'b1; bus.x0 = 11'd3; bus.y0 = 11'd1; bus.rgb0 = 24'h0F0F0F;
    bus.clear_start = 1'b1; bus.clear_rgb = 24'h102030;
    tick();
    bus.clear_start = 1'b0; bus.clear_rgb = 24'h999999;
    repeat (5) tick();
    bus.clear_start = 1'b1;              // ignored mid-clear
    bus.paint_en    = 1'b0;              // ignored mid-clear
    tick();
    bus.clear_start = 1'b0;
    bus.paint_en    = 1'b1;
    repeat (W * H) tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) tick();

    // reset in the middle of a clear
    bus.clear_start = 1'b1; bus.clear_rgb = 24'h445566;
    tick();
    bus.clear_start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    last = 1'b1;
    busy = 0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    bus.req0 = 1'b1; bus.x0 = 11'd4; bus.y0 = 11'd3; bus.rgb0 = 24'h778899;
    tick();
    bus.req0 = 1'b0;
    repeat (3) tick();

    // randomized traffic following the hold-until-transfer protocol
    for (int n = 0; n < 1500; n++) begin
      bus.paint_en    = ($urandom_range(0, 9) != 0);
      bus.clear_start = ($urandom_range(0, 299) == 0);
      bus.clear_rgb   = 24'($urandom());
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1;
        bus.x0   = rand_coord(W);
        bus.y0   = rand_coord(H);
        bus.rgb0 = 24'($urandom());
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1;
        bus.x1   = rand_coord(W);
        bus.y1   = rand_coord(H);
        bus.rgb1 = 24'($urandom());
      end
      tick();
      if (xfer0) bus.req0 = 1'b0;
      if (xfer1) bus.req1 = 1'b0;
    end

    // drain
    idle_inputs();
    repeat (W * H + 4) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
